// File: rtl/pq_pkg.sv
// Shared item type for the register-array priority queue and its clients.
package pq_pkg;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;

endpackage

// File: rtl/ra_pq_arb2.sv
// Two-client round-robin arbiter in front of a register-array priority queue.
// Optional per-client completion counters (gcnt0/gcnt1) with RA_PQ_ARB_STATS_EN.
module ra_pq_arb2
  import pq_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  kv_t         kvi0,
  input  kv_t         kvi1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output kv_t         kvo,
  output logic        pq_enq,
  output logic        pq_deq,
  output kv_t         pq_kvi,
  input  kv_t         pq_kvo,
  input  logic        pq_full,
  input  logic        pq_empty,
  input  logic        pq_busy
`ifdef RA_PQ_ARB_STATS_EN
  ,
  output logic [15:0] gcnt0,
  output logic [15:0] gcnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] WLAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state;
  logic       prio;   // client favoured when both request
  logic       sel;
  logic       op;
  logic [7:0] wcnt;

  logic       any_req;
  logic       win;
  logic       win_op;
  kv_t        win_kv;
  logic       win_rej;

  always_comb begin
    any_req = req0 | req1;
    win     = (req0 & req1) ? prio : req1;
    win_op  = win ? op1 : op0;
    win_kv  = win ? kvi1 : kvi0;
    win_rej = win_op ? pq_full : pq_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      sel    <= 1'b0;
      op     <= 1'b0;
      wcnt   <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      kvo    <= '0;
      pq_enq <= 1'b0;
      pq_deq <= 1'b0;
      pq_kvi <= '0;
`ifdef RA_PQ_ARB_STATS_EN
      gcnt0  <= '0;
      gcnt1  <= '0;
`endif
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      pq_enq <= 1'b0;
      pq_deq <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel    <= win;
            op     <= win_op;
            pq_kvi <= win_kv;
            prio   <= ~win;
            if (win_rej) begin
              // Rejection skips the queue entirely and answers next cycle
              state <= RESP;
              done0 <= ~win;
              done1 <= win;
              err0  <= ~win;
              err1  <= win;
            end else begin
              state  <= ISSUE;
              pq_enq <= win_op;
              pq_deq <= ~win_op;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (!pq_busy) begin
            state <= RESP;
            done0 <= ~sel;
            done1 <= sel;
            if (!op) kvo <= pq_kvo;
`ifdef RA_PQ_ARB_STATS_EN
            if (sel) gcnt1 <= gcnt1 + 16'd1;
            else     gcnt0 <= gcnt0 + 16'd1;
`endif
          end else if (wcnt == WLAST) begin
            state <= RESP;
            done0 <= ~sel;
            done1 <= sel;
            err0  <= ~sel;
            err1  <= sel;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_one_cmd: assert property (@(posedge clk) disable iff (!rst_n) !(pq_enq && pq_deq));
  a_one_done: assert property (@(posedge clk) disable iff (!rst_n) !(done0 && done1));

endmodule
